// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA pixel fetch path.
package vga_pkg;

  localparam int DEF_DATA_W   = 12;
  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/vga_pix_fifo.sv
// Small synchronous show-ahead pixel FIFO with flush.
// DEPTH must be a power of two so the pointers wrap naturally.
// When empty, head_dat keeps showing the last pixel that was at the head.
module vga_pix_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] last_q;
  logic              do_push;
  logic              do_pop;
  logic              non_empty;

  assign non_empty = (count != '0);
  assign do_push   = push && !flush;
  assign do_pop    = pop && non_empty && !flush;
  assign head_dat  = non_empty ? mem[rd_ptr] : last_q;

  // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer/count bookkeeping plus the held copy of the last shown pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (non_empty) begin
        last_q <= mem[rd_ptr];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (do_push && !do_pop) begin
          count <= count + 1'b1;
        end else if (!do_push && do_pop) begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_fetch_ctrl.sv
// Frame fetch controller: streams a frame from an external ROM (1-cycle
// read latency) into a small prefetch FIFO that the display side pops.
// A read is only issued when the FIFO is guaranteed room for its data.
module vga_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int V_LINES    = DEF_V_LINES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  frame_start_in,
  input  logic                                  pix_req_in,
  input  logic [DATA_W-1:0]                     rom_dat_in,
  output logic [$clog2(H_PIXELS*V_LINES)-1:0]   rom_addr_out,
  output logic                                  rom_rd_en_out,
  output logic [DATA_W-1:0]                     pix_dat_out,
  output logic                                  pix_vld_out,
  output logic                                  underflow_out,
  output logic                                  busy_out
);

  localparam int ADDR_W    = $clog2(H_PIXELS*V_LINES);
  localparam int LAST_ADDR = H_PIXELS*V_LINES - 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W:0]    DEPTH_LVL = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(LAST_ADDR);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    level;
  logic              fetching;
  logic              rd_issue;
  logic              at_last;
  logic              fifo_push;
  logic              fifo_pop;

  assign level     = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign fetching  = (state_q == ST_FILL) || (state_q == ST_STREAM);
  assign rd_issue  = fetching && !rst && !frame_start_in && (level < DEPTH_LVL);
  assign at_last   = (addr_q == LAST_A);
  assign fifo_push = inflight_q && !frame_start_in;
  assign fifo_pop  = pix_req_in && pix_vld_out && !frame_start_in;

  assign rom_addr_out  = addr_q;
  assign rom_rd_en_out = rd_issue;
  assign pix_vld_out   = (fifo_count != '0);
  assign underflow_out = pix_req_in && !pix_vld_out && !frame_start_in;
  assign busy_out      = (state_q != ST_IDLE);

  vga_pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (rom_dat_in),
    .pop      (fifo_pop),
    .flush    (frame_start_in),
    .head_dat (pix_dat_out),
    .count    (fifo_count)
  );

  // State, fetch address and outstanding-read flag; frame start restarts from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_issue;
      if (frame_start_in) begin
        addr_q <= '0;
      end else if (rd_issue && !at_last) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Next-state: frame start wins; the final address read sends us to drain.
  always_comb begin
    state_d = state_q;
    if (frame_start_in) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_FILL: begin
          if (rd_issue && at_last) begin
            state_d = ST_DRAIN;
          end else if (fifo_count == DEPTH_CNT) begin
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (rd_issue && at_last) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pix_vld_out && !inflight_q) begin
            state_d = ST_IDLE;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Testbench for vga_fetch_ctrl: directed vector table, corner-case sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_vga_fetch_ctrl;

  localparam int DW    = 12;
  localparam int HP    = 16;
  localparam int VL    = 8;
  localparam int DEPTH = 4;
  localparam int LAST  = HP*VL - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start_in;
  logic          pix_req_in;
  logic [DW-1:0] rom_dat_in;
  logic [6:0]    rom_addr_out;
  logic          rom_rd_en_out;
  logic [DW-1:0] pix_dat_out;
  logic          pix_vld_out;
  logic          underflow_out;
  logic          busy_out;

  logic          s_rst;
  logic          s_fs;
  logic          s_req;
  logic [DW-1:0] s_rom;
  logic [2:0]    s_addr;
  logic          s_rd_en;
  logic [DW-1:0] s_dat;
  logic          s_vld;
  logic          s_uf;
  logic          s_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_fetch_ctrl #(.DATA_W(DW), .H_PIXELS(HP), .V_LINES(VL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .frame_start_in(frame_start_in), .pix_req_in(pix_req_in),
    .rom_dat_in(rom_dat_in), .rom_addr_out(rom_addr_out), .rom_rd_en_out(rom_rd_en_out),
    .pix_dat_out(pix_dat_out), .pix_vld_out(pix_vld_out), .underflow_out(underflow_out),
    .busy_out(busy_out)
  );

  vga_fetch_ctrl #(.DATA_W(DW), .H_PIXELS(4), .V_LINES(2), .FIFO_DEPTH(DEPTH)) dut_s (
    .clk(clk), .rst(s_rst), .frame_start_in(s_fs), .pix_req_in(s_req),
    .rom_dat_in(s_rom), .rom_addr_out(s_addr), .rom_rd_en_out(s_rd_en),
    .pix_dat_out(s_dat), .pix_vld_out(s_vld), .underflow_out(s_uf),
    .busy_out(s_busy)
  );

  function automatic int romf(input int a);
    return (a*37 + 'h5A5) & 'hFFF;
  endfunction

  // External ROMs: one-cycle latency, garbage on the bus when not read.
  always @(posedge clk) begin
    rom_dat_in <= rom_rd_en_out ? DW'(romf(int'(rom_addr_out))) : DW'($urandom);
    s_rom      <= s_rd_en ? DW'(romf(int'(s_addr))) : DW'($urandom);
  end

  int m_q[$];
  bit m_known = 0;
  bit m_infl;
  int m_infl_addr;
  int m_addr;
  int m_phase;
  int m_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_issue();
    return !rst && !frame_start_in && (m_phase == 1 || m_phase == 2) &&
           (m_q.size() + int'(m_infl) < DEPTH);
  endfunction

  task automatic applyStimulus(input bit r, input bit fs, input bit req);
    rst = r;
    frame_start_in = fs;
    pix_req_in = req;
  endtask

  task automatic checkOutput();
    int sz;
    if (!m_known) return;
    sz = m_q.size();
    chk("rd_en", int'(rom_rd_en_out), int'(m_issue()));
    chk("addr", int'(rom_addr_out), m_addr);
    chk("vld", int'(pix_vld_out), int'(sz > 0));
    chk("dat", int'(pix_dat_out), (sz > 0) ? m_q[0] : m_last);
    chk("underflow", int'(underflow_out), int'(pix_req_in && sz == 0 && !frame_start_in));
    chk("busy", int'(busy_out), int'(m_phase != 0));
  endtask

  task automatic modelStep();
    int sz;
    int nxt;
    bit issue;
    if (rst) begin
      m_q.delete();
      m_infl = 0; m_addr = 0; m_phase = 0; m_last = 0; m_known = 1;
      return;
    end
    if (!m_known) return;
    sz = m_q.size();
    issue = m_issue();
    if (sz > 0) m_last = m_q[0];
    if (frame_start_in) begin
      m_q.delete();
      m_infl = 0; m_addr = 0; m_phase = 1;
      return;
    end
    if (pix_req_in && sz > 0) void'(m_q.pop_front());
    if (m_infl) m_q.push_back(romf(m_infl_addr));
    nxt = m_phase;
    if (m_phase == 1 && sz == DEPTH) nxt = 2;
    if (m_phase == 3 && sz == 0 && !m_infl) nxt = 0;
    if (issue) begin
      m_infl = 1;
      m_infl_addr = m_addr;
      if (m_addr == LAST) nxt = 3;
      else m_addr++;
    end else begin
      m_infl = 0;
    end
    m_phase = nxt;
  endtask

  task automatic beginCycle(input bit r, input bit fs, input bit req);
    applyStimulus(r, fs, req);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic endCycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit fs; bit req;
    bit rd; int addr; bit vld; int dat; bit uf; bit busy;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int r0;
    int r1;
    int s_pops;
    int s_last;
    bit done;
    bit found;
    bit got;

    r0 = romf(0);
    r1 = romf(1);
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 0};
    vecs[1]  = '{0, 1, 1, 0, 0, 0,  1, 1};
    vecs[2]  = '{0, 0, 1, 1, 0, 0,  0, 1};
    vecs[3]  = '{0, 0, 1, 2, 1, r0, 0, 1};
    vecs[4]  = '{0, 0, 1, 3, 1, r0, 0, 1};
    vecs[5]  = '{0, 0, 0, 4, 1, r0, 0, 1};
    vecs[6]  = '{0, 0, 0, 4, 1, r0, 0, 1};
    vecs[7]  = '{0, 0, 0, 4, 1, r0, 0, 1};
    vecs[8]  = '{0, 1, 0, 4, 1, r0, 0, 1};
    vecs[9]  = '{0, 0, 1, 4, 1, r1, 0, 1};
    vecs[10] = '{0, 0, 0, 5, 1, r1, 0, 1};
    vecs[11] = '{0, 0, 0, 5, 1, r1, 0, 1};

    s_rst = 1; s_fs = 0; s_req = 0;
    applyStimulus(1, 0, 0);
    @(posedge clk);
    #1;
    beginCycle(1, 0, 0); endCycle();
    beginCycle(1, 0, 0); endCycle();

    for (int i = 0; i < 12; i++) begin
      beginCycle(0, vecs[i].fs, vecs[i].req);
      chk($sformatf("vec%0d_rd", i), int'(rom_rd_en_out), int'(vecs[i].rd));
      chk($sformatf("vec%0d_addr", i), int'(rom_addr_out), vecs[i].addr);
      chk($sformatf("vec%0d_vld", i), int'(pix_vld_out), int'(vecs[i].vld));
      chk($sformatf("vec%0d_dat", i), int'(pix_dat_out), vecs[i].dat);
      chk($sformatf("vec%0d_uf", i), int'(underflow_out), int'(vecs[i].uf));
      chk($sformatf("vec%0d_busy", i), int'(busy_out), int'(vecs[i].busy));
      endCycle();
    end

    s_rst = 0;
    s_fs = 1;
    beginCycle(0, 0, 0); endCycle();
    s_fs = 0;
    s_req = 1;
    s_pops = 0;
    s_last = -1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      beginCycle(0, 0, 0);
      if (s_rd_en) begin
        chk("small_rd_in_range", int'(s_addr <= 3'd7 && s_pops <= 8), 1);
        s_last = int'(s_addr);
      end
      if (s_vld) begin
        chk("small_pix", int'(s_dat), romf(s_pops));
        s_pops++;
      end else if (s_pops == 8 && !s_busy) begin
        done = 1;
      end
      endCycle();
    end
    s_req = 0;
    chk("small_idle_reached", int'(done), 1);
    chk("small_pop_count", s_pops, 8);
    chk("small_last_addr", s_last, 7);
    chk("small_busy_low", int'(s_busy), 0);

    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      beginCycle(0, 0, 1);
      found = rom_rd_en_out && (rom_addr_out == 7'd100);
      endCycle();
    end
    chk("reach_addr100", int'(found), 1);
    beginCycle(0, 1, 1);
    chk("fs_no_underflow", int'(underflow_out), 0);
    endCycle();
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      beginCycle(0, 0, 1);
      if (pix_vld_out) begin
        chk("restart_first_pix", int'(pix_dat_out), romf(0));
        got = 1;
      end
      endCycle();
    end
    chk("restart_pix_seen", int'(got), 1);

    for (int i = 0; i < 10; i++) begin
      beginCycle(0, 0, 1); endCycle();
    end
    beginCycle(1, 0, 0); endCycle();
    beginCycle(0, 0, 0);
    chk("rst_addr", int'(rom_addr_out), 0);
    chk("rst_rd", int'(rom_rd_en_out), 0);
    chk("rst_dat", int'(pix_dat_out), 0);
    chk("rst_vld", int'(pix_vld_out), 0);
    chk("rst_uf", int'(underflow_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    endCycle();
    for (int i = 0; i < 4; i++) begin
      beginCycle(0, 0, 0);
      chk("rst_no_read", int'(rom_rd_en_out), 0);
      endCycle();
    end

    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit fs;
      bit req;
      r   = ($urandom_range(0, 599) == 0);
      fs  = (m_phase == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 99) < 75);
      beginCycle(r, fs, req);
      endCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
